// File: rtl/history_input_arbiter_pkg.sv
// history_arb_pkg: shared definitions for the packet-history input arbiter.
//   - arb_state_t      : arbiter FSM encoding (IDLE=0, PKT=1)
//   - PKT_COUNT_WIDTH  : width of each per-input forwarded-packet counter
//   - DEFAULT_*_WIDTH  : stream widths matching the packet_history datapath
//   - grant_width()    : index width needed to address n requesters
package history_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

  localparam int PKT_COUNT_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH  = 512;
  localparam int DEFAULT_TUSER_WIDTH = 128;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/history_input_arbiter_if.sv
// history_input_arbiter_if: bundle of LANES AXI-Stream channels, flattened.
// Lane k occupies slice k of tdata/tkeep/tuser and bit k of tvalid/tlast/tready.
//   master modport : drives payload/valid/last, receives tready
//   slave modport  : receives payload/valid/last, drives tready
interface history_input_arbiter_if
  import history_arb_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DATA_W = DEFAULT_DATA_WIDTH,
  parameter int USER_W = DEFAULT_TUSER_WIDTH
);

  logic [LANES*DATA_W-1:0]   tdata;
  logic [LANES*DATA_W/8-1:0] tkeep;
  logic [LANES*USER_W-1:0]   tuser;
  logic [LANES-1:0]          tvalid;
  logic [LANES-1:0]          tlast;
  logic [LANES-1:0]          tready;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/history_input_arbiter_rr_priority_sel.sv
// rr_priority_sel: combinational rotating-priority selector.
//   req        : request vector, one bit per requester
//   last_grant : index of the most recently completed grant
//   next_grant : first requester found scanning last_grant+1, +2, ... (mod N);
//                equals last_grant when nothing is requesting
//   any_req    : at least one request bit is set
module rr_priority_sel
  import history_arb_pkg::*;
#(
  parameter int NUM_INPUTS       = 4,
  parameter int NUM_INPUTS_WIDTH = grant_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]       req,
  input  logic [NUM_INPUTS_WIDTH-1:0] last_grant,
  output logic [NUM_INPUTS_WIDTH-1:0] next_grant,
  output logic                        any_req
);

  // One extra bit so last_grant + offset cannot overflow before the wrap.
  localparam int SUM_W = NUM_INPUTS_WIDTH + 1;

  logic [SUM_W-1:0]            cand;
  logic [NUM_INPUTS_WIDTH-1:0] cand_idx;

  // Scan from the farthest offset to the nearest so the nearest requester
  // overwrites any earlier hit; no "found" flag is needed.
  always_comb begin
    next_grant = last_grant;
    any_req    = |req;
    cand       = '0;
    cand_idx   = '0;
    for (int off = NUM_INPUTS; off >= 1; off--) begin
      cand = {1'b0, last_grant} + SUM_W'(off);
      if (cand >= SUM_W'(NUM_INPUTS)) begin
        cand = cand - SUM_W'(NUM_INPUTS);
      end
      cand_idx = cand[NUM_INPUTS_WIDTH-1:0];
      if (req[cand_idx]) begin
        next_grant = cand_idx;
      end
    end
  end

endmodule

// File: rtl/history_input_arbiter.sv
// history_input_arbiter: packet-granular round-robin arbiter feeding the
// packet_history datapath from NUM_INPUTS AXI-Stream requesters.
//   axis_aclk  : clock
//   axis_reset : asynchronous, active-high reset
//   s_axis     : NUM_INPUTS requester lanes (slave side)
//   m_axis     : single registered output stream (master side)
//   grant_idx  : current or most recent grant
//   pkt_count  : per-input count of forwarded packets, 32 bits per input
// A grant is held until the granted input's tlast beat is accepted; one IDLE
// cycle is spent re-arbitrating between packets.
module history_input_arbiter
  import history_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int C_TUSER_WIDTH    = DEFAULT_TUSER_WIDTH,
  parameter int NUM_INPUTS       = 4,
  parameter int NUM_INPUTS_WIDTH = grant_width(NUM_INPUTS)
) (
  input  logic                                   axis_aclk,
  input  logic                                   axis_reset,
  history_input_arbiter_if.slave                 s_axis,
  history_input_arbiter_if.master                m_axis,
  output logic [NUM_INPUTS_WIDTH-1:0]            grant_idx,
  output logic [NUM_INPUTS*PKT_COUNT_WIDTH-1:0]  pkt_count
);

  localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;

  arb_state_t                  state_reg, state_next;
  logic [NUM_INPUTS_WIDTH-1:0] grant_reg, grant_next;
  logic [NUM_INPUTS_WIDTH-1:0] last_grant_reg, last_grant_next;

  logic [C_DATA_WIDTH-1:0]  tdata_reg;
  logic [KEEP_WIDTH-1:0]    tkeep_reg;
  logic [C_TUSER_WIDTH-1:0] tuser_reg;
  logic                     tvalid_reg;
  logic                     tlast_reg;

  logic [NUM_INPUTS-1:0]       ready_vec;
  logic                        out_free;
  logic                        in_accept;
  logic                        in_last;
  logic [NUM_INPUTS_WIDTH-1:0] sel_grant;
  logic                        sel_any;

  logic [C_DATA_WIDTH-1:0]  in_tdata [NUM_INPUTS];
  logic [KEEP_WIDTH-1:0]    in_tkeep [NUM_INPUTS];
  logic [C_TUSER_WIDTH-1:0] in_tuser [NUM_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : gen_unpack
      assign in_tdata[gi] = s_axis.tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign in_tkeep[gi] = s_axis.tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign in_tuser[gi] = s_axis.tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH];
    end
  endgenerate

  rr_priority_sel #(
    .NUM_INPUTS       (NUM_INPUTS),
    .NUM_INPUTS_WIDTH (NUM_INPUTS_WIDTH)
  ) u_rr_sel (
    .req        (s_axis.tvalid),
    .last_grant (last_grant_reg),
    .next_grant (sel_grant),
    .any_req    (sel_any)
  );

  // The output register can take a new beat when empty or being drained.
  assign out_free = !tvalid_reg || m_axis.tready[0];

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_reg      <= IDLE;
      grant_reg      <= NUM_INPUTS_WIDTH'(NUM_INPUTS - 1);
      last_grant_reg <= NUM_INPUTS_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    ready_vec       = '0;
    in_accept       = 1'b0;
    in_last         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          grant_next = sel_grant;
          state_next = PKT;
        end
      end
      PKT: begin
        ready_vec[grant_reg] = out_free;
        in_accept            = s_axis.tvalid[grant_reg] && out_free;
        in_last              = in_accept && s_axis.tlast[grant_reg];
        if (in_last) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload only loads when out_free, so it is frozen while stalled.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      tdata_reg  <= '0;
      tkeep_reg  <= '0;
      tuser_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
    end else if (in_accept) begin
      tdata_reg  <= in_tdata[grant_reg];
      tkeep_reg  <= in_tkeep[grant_reg];
      tuser_reg  <= in_tuser[grant_reg];
      tvalid_reg <= 1'b1;
      tlast_reg  <= s_axis.tlast[grant_reg];
    end else if (m_axis.tready[0]) begin
      tvalid_reg <= 1'b0;
    end
  end

  // Per-input packet counters; wrap naturally at 2^32.
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : gen_cnt
      logic [PKT_COUNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
          cnt_reg <= '0;
        end else if (in_last && (grant_reg == NUM_INPUTS_WIDTH'(gi))) begin
          cnt_reg <= cnt_reg + PKT_COUNT_WIDTH'(1);
        end
      end
      assign pkt_count[gi*PKT_COUNT_WIDTH +: PKT_COUNT_WIDTH] = cnt_reg;
    end
  endgenerate

  assign s_axis.tready    = ready_vec;
  assign m_axis.tdata     = tdata_reg;
  assign m_axis.tkeep     = tkeep_reg;
  assign m_axis.tuser     = tuser_reg;
  assign m_axis.tvalid[0] = tvalid_reg;
  assign m_axis.tlast[0]  = tlast_reg;
  assign grant_idx        = grant_reg;

endmodule

// File: tb/tb_history_input_arbiter.sv
// Bench for history_input_arbiter: directed packets on four requesters, a
// queue-based scoreboard checked every cycle, plus literal expectations.
module tb_history_input_arbiter;
  import history_arb_pkg::*;

  localparam int NI = 4;
  localparam int DW = 512;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int GW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic axis_aclk  = 1'b0;
  logic axis_reset = 1'b1;
  always #5 axis_aclk = ~axis_aclk;

  history_input_arbiter_if #(.LANES(NI), .DATA_W(DW), .USER_W(UW)) s_if ();
  history_input_arbiter_if #(.LANES(1),  .DATA_W(DW), .USER_W(UW)) m_if ();
  logic [GW-1:0]   grant_idx;
  logic [NI*32-1:0] pkt_count;

  history_input_arbiter #(
    .C_DATA_WIDTH (DW), .C_TUSER_WIDTH (UW), .NUM_INPUTS (NI), .NUM_INPUTS_WIDTH (GW)
  ) dut (
    .axis_aclk  (axis_aclk),
    .axis_reset (axis_reset),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .grant_idx  (grant_idx),
    .pkt_count  (pkt_count)
  );

  int checks = 0;
  int errors = 0;

  beat_t src_q [NI][$];
  logic  hold  [NI];

  // Model state
  beat_t       exp_q[$];
  logic [31:0] mcnt [NI];
  bit          in_pkt;
  int          owner;
  int          start_log[$];
  logic [31:0] out_word_log[$];
  int          out_cyc_log[$];
  int          cyc = 0;
  bit          prev_stall;
  beat_t       prev_out;

  task automatic chk_val(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_word(input int k, input int p, input int b);
    return 32'hA000_0000 | 32'(k << 16) | 32'(p << 8) | 32'(b);
  endfunction

  function automatic beat_t mk_beat(input int k, input int p, input int b, input bit last);
    beat_t r;
    logic [31:0] w;
    w      = mk_word(k, p, b);
    r.data = {16{w}};
    r.keep = {8{w[7:0] ^ 8'h5A}};
    r.user = {4{~w}};
    r.last = last;
    return r;
  endfunction

  task automatic load_pkt(input int k, input int p, input int nbeats);
    for (int b = 0; b < nbeats; b++) src_q[k].push_back(mk_beat(k, p, b, b == nbeats - 1));
  endtask

  // Source driver: pops a beat after its handshake, presents the next one.
  initial begin : drv
    logic [NI-1:0] hs;
    beat_t b;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    for (int k = 0; k < NI; k++) hold[k] = 1'b0;
    forever begin
      @(negedge axis_aclk);
      hs = s_if.tvalid & s_if.tready;
      @(posedge axis_aclk);
      #1;
      for (int k = 0; k < NI; k++) begin
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && !hold[k]) begin
          b = src_q[k][0];
          s_if.tdata[k*DW +: DW] = b.data;
          s_if.tkeep[k*KW +: KW] = b.keep;
          s_if.tuser[k*UW +: UW] = b.user;
          s_if.tvalid[k] = 1'b1;
          s_if.tlast[k]  = b.last;
        end else begin
          s_if.tdata[k*DW +: DW] = '0;
          s_if.tkeep[k*KW +: KW] = '0;
          s_if.tuser[k*UW +: UW] = '0;
          s_if.tvalid[k] = 1'b0;
          s_if.tlast[k]  = 1'b0;
        end
      end
    end
  end

  // Compare process: checks outputs against the model, then advances it.
  always @(negedge axis_aclk) begin : cmp
    beat_t cur;
    beat_t inb;
    logic [NI-1:0] other;
    cyc++;
    cur.data = m_if.tdata;
    cur.keep = m_if.tkeep;
    cur.user = m_if.tuser;
    cur.last = m_if.tlast[0];
    if (axis_reset) begin
      chk_val("reset_m_tvalid", m_if.tvalid, 0);
      chk_val("reset_m_tdata", m_if.tdata, 0);
      chk_val("reset_s_tready", s_if.tready, 0);
      chk_val("reset_grant_idx", grant_idx, NI - 1);
      chk_val("reset_pkt_count", pkt_count, 0);
      exp_q.delete();
      for (int k = 0; k < NI; k++) mcnt[k] = '0;
      in_pkt     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk_val("out_occupancy", m_if.tvalid, exp_q.size());
      if (m_if.tvalid[0] && exp_q.size() > 0) begin
        chk_val("out_tdata", cur.data, exp_q[0].data);
        chk_val("out_tkeep", cur.keep, exp_q[0].keep);
        chk_val("out_tuser", cur.user, exp_q[0].user);
        chk_val("out_tlast", cur.last, exp_q[0].last);
      end
      if (prev_stall) chk_val("out_stable", cur, prev_out);
      chk_val("tready_onehot", ($countones(s_if.tready) <= 1), 1);
      if (m_if.tvalid[0] && !m_if.tready[0]) chk_val("tready_while_full", s_if.tready, 0);
      if (in_pkt) begin
        other = s_if.tready;
        other[owner] = 1'b0;
        chk_val("grant_held", grant_idx, owner);
        chk_val("tready_other", other, 0);
        if (!m_if.tvalid[0] || m_if.tready[0]) chk_val("tready_granted", s_if.tready[owner], 1);
      end
      for (int k = 0; k < NI; k++) chk_val($sformatf("pkt_count%0d", k), pkt_count[k*32 +: 32], mcnt[k]);

      // Advance the model for the coming clock edge.
      if (m_if.tvalid[0] && m_if.tready[0] && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        out_word_log.push_back(cur.data[31:0]);
        out_cyc_log.push_back(cyc);
      end
      for (int k = 0; k < NI; k++) begin
        if (s_if.tvalid[k] && s_if.tready[k]) begin
          if (in_pkt) chk_val("no_interleave", k, owner);
          if (!in_pkt) begin
            start_log.push_back(k);
            in_pkt = 1'b1;
            owner  = k;
          end
          inb.data = s_if.tdata[k*DW +: DW];
          inb.keep = s_if.tkeep[k*KW +: KW];
          inb.user = s_if.tuser[k*UW +: UW];
          inb.last = s_if.tlast[k];
          exp_q.push_back(inb);
          if (inb.last) begin
            in_pkt  = 1'b0;
            mcnt[k] = mcnt[k] + 32'd1;
          end
        end
      end
      prev_stall = m_if.tvalid[0] && !m_if.tready[0];
      prev_out   = cur;
    end
  end

  task automatic do_reset();
    @(posedge axis_aclk); #3;
    axis_reset = 1'b1;
    @(posedge axis_aclk); #2;
    for (int k = 0; k < NI; k++) begin
      src_q[k].delete();
      hold[k] = 1'b0;
    end
    start_log.delete();
    out_word_log.delete();
    out_cyc_log.delete();
    @(posedge axis_aclk); #3;
    axis_reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(posedge axis_aclk); #2;
      done = !m_if.tvalid[0] && exp_q.size() == 0 &&
             src_q[0].size() == 0 && src_q[1].size() == 0 &&
             src_q[2].size() == 0 && src_q[3].size() == 0;
    end
    chk_val({name, "_timeout"}, done, 1);
  endtask

  int t2_order[6] = '{0, 1, 2, 3, 0, 1};
  int t2_pkt[6]   = '{0, 0, 0, 0, 1, 1};

  initial begin : main
    bit ok;
    m_if.tready = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #2;
    chk_val("init_grant_idx", grant_idx, 3);
    chk_val("init_m_tvalid", m_if.tvalid, 0);
    #1;
    axis_reset = 1'b0;

    // 1: single-beat packet on input 2
    do_reset();
    @(posedge axis_aclk); #2;
    load_pkt(2, 0, 1);
    @(posedge axis_aclk); #2;
    chk_val("t1_grant_before", grant_idx, 3);
    @(posedge axis_aclk); #2;
    chk_val("t1_grant", grant_idx, 2);
    chk_val("t1_not_yet_valid", m_if.tvalid, 0);
    @(posedge axis_aclk); #2;
    chk_val("t1_valid", m_if.tvalid, 1);
    chk_val("t1_word", m_if.tdata[31:0], 32'hA002_0000);
    chk_val("t1_tlast", m_if.tlast, 1);
    chk_val("t1_pkt_count2", pkt_count[95:64], 1);
    wait_idle("t1", 20);

    // 2: all four inputs present 3-beat packets back to back
    do_reset();
    @(posedge axis_aclk); #2;
    for (int k = 0; k < NI; k++) load_pkt(k, 0, 3);
    load_pkt(0, 1, 3);
    load_pkt(1, 1, 3);
    wait_idle("t2", 100);
    chk_val("t2_npkts", start_log.size(), 6);
    for (int i = 0; i < 6 && i < start_log.size(); i++)
      chk_val($sformatf("t2_order%0d", i), start_log[i], t2_order[i]);
    chk_val("t2_nbeats", out_word_log.size(), 18);
    if (out_word_log.size() == 18) begin
      chk_val("t2_pin_word3", out_word_log[3], 32'hA001_0000);
      chk_val("t2_pin_word12", out_word_log[12], 32'hA000_0100);
      for (int i = 0; i < 18; i++)
        chk_val($sformatf("t2_word%0d", i), out_word_log[i], mk_word(t2_order[i/3], t2_pkt[i/3], i%3));
      for (int i = 1; i < 18; i++)
        chk_val($sformatf("t2_gap%0d", i), out_cyc_log[i] - out_cyc_log[i-1], (i % 3 == 0) ? 2 : 1);
    end

    // 3: input 1, 4 beats, output ready toggling 1,0,0,1
    do_reset();
    @(posedge axis_aclk); #2;
    load_pkt(1, 0, 4);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      m_if.tready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge axis_aclk); #2;
      ok = src_q[1].size() == 0 && !m_if.tvalid[0];
    end
    m_if.tready = 1'b1;
    wait_idle("t3", 20);
    chk_val("t3_nbeats", out_word_log.size(), 4);
    for (int i = 0; i < 4 && i < out_word_log.size(); i++)
      chk_val($sformatf("t3_word%0d", i), out_word_log[i], 32'hA001_0000 | 32'(i));

    // 4: input 0 drops tvalid mid-packet while input 3 waits
    do_reset();
    @(posedge axis_aclk); #2;
    load_pkt(0, 0, 3);
    load_pkt(3, 0, 2);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge axis_aclk); #2;
      ok = src_q[0].size() <= 2;
    end
    chk_val("t4_first_beat_timeout", ok, 1);
    hold[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge axis_aclk); #2;
      chk_val("t4_grant_held", grant_idx, 0);
      chk_val("t4_tready3", s_if.tready[3], 0);
    end
    hold[0] = 1'b0;
    wait_idle("t4", 40);
    chk_val("t4_npkts", start_log.size(), 2);
    if (start_log.size() == 2) begin
      chk_val("t4_first", start_log[0], 0);
      chk_val("t4_second", start_log[1], 3);
    end

    // 5: asynchronous reset during beat 2 of a packet
    do_reset();
    @(posedge axis_aclk); #2;
    load_pkt(2, 0, 1);
    wait_idle("t5_pre", 20);
    load_pkt(1, 0, 4);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge axis_aclk); #2;
      ok = src_q[1].size() <= 2;
    end
    chk_val("t5_beat2_timeout", ok, 1);
    #1;
    axis_reset = 1'b1;
    #1;
    chk_val("t5_async_tvalid", m_if.tvalid, 0);
    chk_val("t5_async_tready", s_if.tready, 0);
    chk_val("t5_async_grant", grant_idx, 3);
    chk_val("t5_async_count", pkt_count, 0);
    @(posedge axis_aclk); #2;
    for (int k = 0; k < NI; k++) src_q[k].delete();
    start_log.delete();
    load_pkt(1, 1, 1);
    load_pkt(3, 1, 1);
    load_pkt(0, 1, 1);
    @(posedge axis_aclk); #3;
    axis_reset = 1'b0;
    wait_idle("t5", 40);
    chk_val("t5_npkts", start_log.size(), 3);
    if (start_log.size() == 3) begin
      chk_val("t5_first", start_log[0], 0);
      chk_val("t5_second", start_log[1], 1);
      chk_val("t5_third", start_log[2], 3);
    end

    // 6: pkt_count wrap
    do_reset();
    @(posedge axis_aclk); #2;
    force dut.gen_cnt[1].cnt_reg = 32'hFFFF_FFFF;
    mcnt[1] = 32'hFFFF_FFFF;
    @(posedge axis_aclk); #2;
    release dut.gen_cnt[1].cnt_reg;
    @(posedge axis_aclk); #2;
    chk_val("t6_preload", pkt_count[63:32], 32'hFFFF_FFFF);
    load_pkt(1, 0, 2);
    wait_idle("t6", 20);
    chk_val("t6_wrap", pkt_count[63:32], 0);

    repeat (2) @(posedge axis_aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
